imem_loader: RTL

//  Boot loader that sits in front of simple_cpu. It holds the core in reset and streams a program

---
 rtl/imem_loader_pkg.sv | 28 ++
 rtl/imem_loader_packer.sv | 38 +++
 rtl/imem_loader.sv | 129 ++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory boot loader.
// Bytes are packed little-endian into 32-bit words.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;

    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_ERROR   = 3'd4
    } state_e;

    // Place byte b at lane idx of word, leaving the other lanes untouched.
    function automatic logic [WORD_W-1:0] insert_byte(
        input logic [WORD_W-1:0] word,
        input logic [1:0]        idx,
        input logic [7:0]        b
    );
        logic [WORD_W-1:0] res;
        res = word;
        res[{idx, 3'b000} +: 8] = b;
        return res;
    endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// Byte packer: collects up to four bytes into a little-endian word.
// Lanes not yet written stay zero because the word is cleared after every write.
module imem_loader_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              accept,
    input  logic              clear,
    input  logic [7:0]        data,
    output logic              word_full,
    output logic [WORD_W-1:0] word_next
);

    logic [1:0]        idx_r;
    logic [WORD_W-1:0] word_r;

    assign word_next = insert_byte(word_r, idx_r, data);
    assign word_full = accept && (idx_r == 2'd3);

    // Byte lane index and partial word storage; clear wins over a new byte.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_r  <= 2'd0;
            word_r <= 32'h0000_0000;
        end else if (clear) begin
            idx_r  <= 2'd0;
            word_r <= 32'h0000_0000;
        end else if (accept) begin
            idx_r  <= idx_r + 2'd1;
            word_r <= word_next;
        end else begin
            idx_r  <= idx_r;
            word_r <= word_r;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: holds the core in reset, streams bytes into instruction memory
// one word per write, then releases the core after a fixed delay.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int IMEM_DEPTH    = 64,
    parameter int ADDR_W        = 6,
    parameter int RELEASE_DELAY = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [7:0]        s_byte,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_rstn,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   word_count
);

    state_e            state_r;
    logic              last_r;
    logic [3:0]        rel_cnt_r;
    logic              accept_s;
    logic              at_limit_s;
    logic              pack_accept_s;
    logic              pack_clear_s;
    logic              word_full_s;
    logic [WORD_W-1:0] word_next_s;

    assign accept_s      = s_valid && s_ready;
    assign at_limit_s    = (word_count == (ADDR_W+1)'(IMEM_DEPTH));
    assign pack_accept_s = accept_s && !at_limit_s;
    assign pack_clear_s  = (state_r == ST_WRITE);

    imem_loader_packer u_packer (
        .clk       (clk),
        .rstn      (rstn),
        .accept    (pack_accept_s),
        .clear     (pack_clear_s),
        .data      (s_byte),
        .word_full (word_full_s),
        .word_next (word_next_s)
    );

    // Loader FSM with all outputs registered; imem write data is captured
    // on the edge that accepts the word's final byte.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_LOAD;
            last_r     <= 1'b0;
            rel_cnt_r  <= 4'd0;
            s_ready    <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'h0000_0000;
            cpu_rstn   <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            word_count <= '0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    imem_we <= 1'b0;
                    if (accept_s && at_limit_s) begin
                        state_r    <= ST_ERROR;
                        s_ready    <= 1'b0;
                        load_error <= 1'b1;
                    end else if (accept_s && (word_full_s || s_last)) begin
                        state_r    <= ST_WRITE;
                        s_ready    <= 1'b0;
                        imem_we    <= 1'b1;
                        imem_addr  <= word_count[ADDR_W-1:0];
                        imem_wdata <= word_next_s;
                        last_r     <= s_last;
                    end else begin
                        s_ready <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    imem_we    <= 1'b0;
                    word_count <= word_count + (ADDR_W+1)'(1);
                    if (last_r) begin
                        state_r   <= ST_RELEASE;
                        rel_cnt_r <= 4'(RELEASE_DELAY);
                        s_ready   <= 1'b0;
                    end else begin
                        state_r <= ST_LOAD;
                        s_ready <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    s_ready <= 1'b0;
                    // The core leaves reset on the edge that would take the count to zero.
                    if (rel_cnt_r <= 4'd1) begin
                        state_r   <= ST_RUN;
                        rel_cnt_r <= 4'd0;
                        cpu_rstn  <= 1'b1;
                        load_done <= 1'b1;
                    end else begin
                        rel_cnt_r <= rel_cnt_r - 4'd1;
                    end
                end
                ST_RUN: begin
                    s_ready   <= 1'b0;
                    cpu_rstn  <= 1'b1;
                    load_done <= 1'b1;
                end
                ST_ERROR: begin
                    s_ready    <= 1'b0;
                    cpu_rstn   <= 1'b0;
                    load_error <= 1'b1;
                end
                default: begin
                    state_r    <= ST_ERROR;
                    s_ready    <= 1'b0;
                    imem_we    <= 1'b0;
                    cpu_rstn   <= 1'b0;
                    load_error <= 1'b1;
                end
            endcase
        end
    end

endmodule
